life_step_controller: RTL and testbench

LIFE_STEP_CONTROLLER -- requirements
Module: life_step_controller

---
 rtl/life_pkg.sv | 14 +
 rtl/gen_counter.sv | 33 +++
 rtl/life_step_controller.sv | 147 ++++++++++++++
 tb/tb_life_step_controller.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared types and defaults for the Life step controller.
package life_pkg;

    // Step sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } life_state_e;

    // Default width of the generation counter.
    localparam int GEN_W_DEFAULT = 16;

endpackage

// File: rtl/gen_counter.sv
// Generation counter: wrapping up-counter with synchronous active-low clear.
module gen_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_b,
    input  logic             inc_en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // Next count: increment on enable, natural wrap at all-ones.
    always_comb begin
        count_d = count_q;
        if (inc_en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!clr_b) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/life_step_controller.sv
// Life step controller: issues step requests to the board update engine on
// timer ticks (run) or single-step presses (paused), counts completed steps
// and flags dropped ticks.
// Optional feature: define LIFE_STEP_TIMEOUT_EN to abandon a request that is
// not acknowledged within TIMEOUT_CYCLES clocks.
//
// state | meaning
// IDLE  | waiting for a tick (run=1) or step_btn (run=0)
// REQ   | step_req asserted, waiting for step_ack
// DONE  | one-cycle completion slot; new triggers are not queued
module life_step_controller
    import life_pkg::*;
#(
    parameter int GEN_W          = GEN_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             run,
    input  logic             step_btn,
    input  logic             clr_flags,
    input  logic             step_ack,
    output logic             step_req,
    output logic [GEN_W-1:0] generation,
    output logic             busy,
    output logic             overrun,
    output logic             timeout
);

    life_state_e state_d, state_q;
    logic        step_req_d, step_req_q;
    logic        overrun_d, overrun_q;
    logic        trigger;
    logic        gen_inc;

`ifdef LIFE_STEP_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] tmr_d, tmr_q;
    logic             timeout_d, timeout_q;
    logic             timeout_set;
`endif

    assign trigger = (run & tick_in) | (~run & step_btn);

    // Next-state logic; request flag is registered from the next state.
    always_comb begin
        state_d = state_q;
        gen_inc = 1'b0;
`ifdef LIFE_STEP_TIMEOUT_EN
        timeout_set = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (step_ack) begin
                    state_d = DONE;
                    gen_inc = 1'b1;
                end
`ifdef LIFE_STEP_TIMEOUT_EN
                else if (tmr_q == '0) begin
                    state_d     = IDLE;
                    timeout_set = 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        step_req_d = (state_d == REQ);
    end

    // Sticky overrun: a tick seen while busy is dropped; set beats clear.
    always_comb begin
        overrun_d = overrun_q & ~clr_flags;
        if (run && tick_in && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // State, request and flag registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            step_req_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_req_q <= step_req_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef LIFE_STEP_TIMEOUT_EN
    // Down-counter loaded on entry to REQ; terminal count zero abandons.
    always_comb begin
        tmr_d     = tmr_q;
        timeout_d = timeout_set | (timeout_q & ~clr_flags);
        if ((state_q == IDLE) && (state_d == REQ)) begin
            tmr_d = TMR_LOAD;
        end else if ((state_q == REQ) && (tmr_q != '0)) begin
            tmr_d = tmr_q - TMR_W'(1);
        end
    end

    // Timeout counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmr_q     <= tmr_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    // No timeout hardware: the flag is permanently low and TIMEOUT_CYCLES
    // only keeps the parameter interface identical across builds.
    assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    gen_counter #(
        .WIDTH (GEN_W)
    ) u_gen_counter (
        .clk    (clk),
        .clr_b  (rst),
        .inc_en (gen_inc),
        .count  (generation)
    );

    assign step_req = step_req_q;
    assign busy     = (state_q != IDLE);
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_life_step_controller.sv
// Directed self-checking bench for life_step_controller (GEN_W=4,
// TIMEOUT_CYCLES=8). Inputs change 1ns after posedge; outputs are sampled
// at the same point, i.e. they reflect the edge just taken.
module tb_life_step_controller;

    localparam int GW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick_in, run, step_btn, clr_flags, step_ack;
    logic          step_req, busy, overrun, timeout;
    logic [GW-1:0] generation;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    life_step_controller #(
        .GEN_W          (GW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_in    (tick_in),
        .run        (run),
        .step_btn   (step_btn),
        .clr_flags  (clr_flags),
        .step_ack   (step_ack),
        .step_req   (step_req),
        .generation (generation),
        .busy       (busy),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Run-mode step: tick, one REQ cycle, ack, DONE, back to IDLE.
    task automatic run_step();
        tick_in = 1'b1; cyc(); tick_in = 1'b0;
        step_ack = 1'b1; cyc(); step_ack = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b0; tick_in = 1'b0; run = 1'b0; step_btn = 1'b0;
        clr_flags = 1'b0; step_ack = 1'b0;
        cyc(); cyc();
        chk("rst_step_req", 32'(step_req), 0);
        chk("rst_gen", 32'(generation), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_timeout", 32'(timeout), 0);
        rst = 1'b1;
        cyc();

        // Run mode: tick, request held 4 cycles, ack, generation 1.
        run = 1'b1;
        tick_in = 1'b1; cyc(); tick_in = 1'b0;
        chk("run_req_c1", 32'(step_req), 1);
        cyc(); cyc(); cyc();
        chk("run_req_c4", 32'(step_req), 1);
        chk("run_gen_before_ack", 32'(generation), 0);
        step_ack = 1'b1; cyc(); step_ack = 1'b0;
        chk("run_req_after_ack", 32'(step_req), 0);
        chk("run_gen_after_ack", 32'(generation), 1);
        chk("run_busy_done", 32'(busy), 1);
        cyc();
        chk("run_busy_idle", 32'(busy), 0);

        // Overrun: second tick while in REQ is dropped.
        tick_in = 1'b1; cyc();
        chk("ovr_req", 32'(step_req), 1);
        cyc(); tick_in = 1'b0;
        chk("ovr_set", 32'(overrun), 1);
        chk("ovr_req_held", 32'(step_req), 1);
        step_ack = 1'b1; cyc(); step_ack = 1'b0;
        cyc();
        chk("ovr_gen_plus1", 32'(generation), 2);
        chk("ovr_idle", 32'(busy), 0);
        clr_flags = 1'b1; cyc(); clr_flags = 1'b0;
        chk("ovr_cleared", 32'(overrun), 0);
        // Clear together with a new overrun: set wins.
        tick_in = 1'b1; cyc();
        clr_flags = 1'b1; cyc(); tick_in = 1'b0; clr_flags = 1'b0;
        chk("ovr_set_beats_clr", 32'(overrun), 1);
        step_ack = 1'b1; cyc(); step_ack = 1'b0;
        cyc();
        chk("ovr_gen3", 32'(generation), 3);
        clr_flags = 1'b1; cyc(); clr_flags = 1'b0;
        chk("ovr_cleared2", 32'(overrun), 0);

        // Paused: tick ignored, step_btn gives one request.
        run = 1'b0;
        tick_in = 1'b1; cyc(); tick_in = 1'b0;
        chk("pause_tick_ignored", 32'(busy), 0);
        step_ack = 1'b1; cyc(); step_ack = 1'b0;
        chk("idle_ack_ignored", 32'(generation), 3);
        step_btn = 1'b1; cyc(); step_btn = 1'b0;
        chk("btn_req", 32'(step_req), 1);
        cyc();
        chk("btn_single_req", 32'(step_req), 1);
        step_ack = 1'b1; cyc(); step_ack = 1'b0;
        chk("btn_gen4", 32'(generation), 4);
        // Ack during DONE ignored.
        step_ack = 1'b1; cyc(); step_ack = 1'b0;
        chk("done_ack_ignored", 32'(generation), 4);
        chk("btn_back_idle", 32'(busy), 0);
        // Run=1: step_btn ignored.
        run = 1'b1;
        step_btn = 1'b1; cyc(); step_btn = 1'b0;
        chk("run_btn_ignored", 32'(busy), 0);

        // Changing run while in REQ keeps the request.
        run = 1'b0;
        step_btn = 1'b1; cyc(); step_btn = 1'b0;
        run = 1'b1; cyc();
        chk("run_change_req", 32'(step_req), 1);
        step_ack = 1'b1; cyc(); step_ack = 1'b0;
        cyc();
        chk("run_change_gen5", 32'(generation), 5);

        // Wrap: 10 more steps to 15, one more to 0.
        for (int i = 0; i < 10; i++) run_step();
        chk("wrap_gen15", 32'(generation), 15);
        run_step();
        chk("wrap_gen0", 32'(generation), 0);
        chk("wrap_no_overrun", 32'(overrun), 0);
        chk("wrap_no_timeout", 32'(timeout), 0);

        // Single more step so reset visibly clears generation.
        run_step();
        chk("pre_rst_gen1", 32'(generation), 1);
        tick_in = 1'b1; cyc(); tick_in = 1'b0;
        chk("pre_rst_req", 32'(step_req), 1);
        rst = 1'b0; cyc(); rst = 1'b1;
        chk("mid_rst_req", 32'(step_req), 0);
        chk("mid_rst_gen", 32'(generation), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_overrun", 32'(overrun), 0);
        chk("mid_rst_timeout", 32'(timeout), 0);
        step_ack = 1'b1; cyc(); step_ack = 1'b0;
        cyc();
        chk("late_ack_gen", 32'(generation), 0);
        chk("late_ack_busy", 32'(busy), 0);

        // Timeout behaviour.
        tick_in = 1'b1; cyc(); tick_in = 1'b0;
`ifdef LIFE_STEP_TIMEOUT_EN
        repeat (7) cyc();
        chk("to_req_cycle8", 32'(step_req), 1);
        cyc();
        chk("to_req_dropped", 32'(step_req), 0);
        chk("to_flag", 32'(timeout), 1);
        chk("to_gen", 32'(generation), 0);
        chk("to_idle", 32'(busy), 0);
        clr_flags = 1'b1; cyc(); clr_flags = 1'b0;
        chk("to_cleared", 32'(timeout), 0);
`else
        repeat (100) cyc();
        chk("noto_req_held", 32'(step_req), 1);
        chk("noto_flag", 32'(timeout), 0);
        step_ack = 1'b1; cyc(); step_ack = 1'b0;
        chk("noto_gen", 32'(generation), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
